// File: rtl/mrd_stage_ctrl_if.sv
// rtl/mrd_stage_ctrl_if.sv - packet config, engine pulses and stage outputs of the stage sequencer
interface mrd_stage_ctrl_if #(
  parameter int W_PTS = 12
);
  logic             start;
  logic [W_PTS-1:0] dftpts;
  logic [2:0]       num_factors;
  logic [17:0]      nf;
  logic             rd_end;
  logic             wr_end;
  logic             source_end;
  logic             busy;
  logic             stage_go;
  logic [2:0]       cnt_stage;
  logic [2:0]       stage_nf;
  logic [W_PTS-1:0] twdl_demontr;
  logic             last_stage;
  logic             source_go;
  logic             done;
  logic             err_cfg;
  logic             err_timeout;

  modport master (
    output start, dftpts, num_factors, nf, rd_end, wr_end, source_end,
    input  busy, stage_go, cnt_stage, stage_nf, twdl_demontr, last_stage,
           source_go, done, err_cfg, err_timeout
  );

  modport slave (
    input  start, dftpts, num_factors, nf, rd_end, wr_end, source_end,
    output busy, stage_go, cnt_stage, stage_nf, twdl_demontr, last_stage,
           source_go, done, err_cfg, err_timeout
  );
endinterface

// File: rtl/mrd_stage_ctrl.sv
// rtl/mrd_stage_ctrl.sv - per-packet factor validation and RD/WR/SOURCE stage sequencer with watchdog
module mrd_stage_ctrl #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd8191,
  parameter int          W_PTS       = 12
) (
  input logic             clk,
  input logic             rst_n,
  mrd_stage_ctrl_if.slave bus
);
  localparam int PW = W_PTS + 3;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_CHECK, S_RD, S_WAIT_WR, S_SOURCE
  } state_t;

  state_t           state;
  logic [W_PTS-1:0] dftpts_q;
  logic [2:0]       nfac_q;
  logic [17:0]      nf_q;
  logic [PW-1:0]    prod;
  logic [2:0]       idx;
  logic             wr_pend;
  logic [15:0]      wd;
  logic             stage_go_q;
  logic             source_go_q;
  logic             done_q;
  logic [2:0]       cnt_stage_q;
  logic [2:0]       stage_nf_q;
  logic [W_PTS-1:0] twdl_q;
  logic             last_q;
  logic             err_cfg_q;
  logic             err_to_q;

  logic [2:0]       cfg_f;
  logic [PW-1:0]    prod_mul;
  logic [2:0]       next_idx;
  logic [2:0]       next_f;
  logic [W_PTS-1:0] tw_mul;
  logic             cfg_bad;
  logic [15:0]      wd_inc;
  logic             wd_hit;

  function automatic logic [2:0] factor_at(input logic [17:0] v, input logic [2:0] i);
    case (i)
      3'd0:    return v[2:0];
      3'd1:    return v[5:3];
      3'd2:    return v[8:6];
      3'd3:    return v[11:9];
      3'd4:    return v[14:12];
      3'd5:    return v[17:15];
      default: return 3'd0;
    endcase
  endfunction

  // prod carries 3 spare bits so a single oversize multiply is still visible
  always_comb begin
    cfg_f    = factor_at(nf_q, idx);
    prod_mul = prod * PW'(cfg_f);
    next_idx = cnt_stage_q + 3'd1;
    next_f   = factor_at(nf_q, next_idx);
    tw_mul   = twdl_q * W_PTS'(next_f);
    cfg_bad  = (cfg_f < 3'd2) || (cfg_f > 3'd5) ||
               (prod_mul[PW-1:W_PTS] != '0) ||
               ((idx == 3'd0) && ((nfac_q == 3'd0) || (nfac_q > 3'd6)));
    wd_inc   = wd + 16'd1;
    wd_hit   = (wd_inc == TIMEOUT_CYC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dftpts_q    <= '0;
      nfac_q      <= '0;
      nf_q        <= '0;
      prod        <= '0;
      idx         <= '0;
      wr_pend     <= 1'b0;
      wd          <= '0;
      stage_go_q  <= 1'b0;
      source_go_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_stage_q <= '0;
      stage_nf_q  <= '0;
      twdl_q      <= '0;
      last_q      <= 1'b0;
      err_cfg_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      stage_go_q  <= 1'b0;
      source_go_q <= 1'b0;
      done_q      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            dftpts_q    <= bus.dftpts;
            nfac_q      <= bus.num_factors;
            nf_q        <= bus.nf;
            prod        <= PW'(1);
            idx         <= '0;
            wr_pend     <= 1'b0;
            wd          <= '0;
            cnt_stage_q <= '0;
            stage_nf_q  <= '0;
            twdl_q      <= '0;
            last_q      <= 1'b0;
            err_cfg_q   <= 1'b0;
            err_to_q    <= 1'b0;
            state       <= S_CFG;
          end
        end
        S_CFG: begin
          if (cfg_bad) begin
            err_cfg_q <= 1'b1;
            state     <= S_IDLE;
          end else begin
            prod <= prod_mul;
            idx  <= idx + 3'd1;
            if (idx == nfac_q - 3'd1) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (prod != PW'(dftpts_q)) begin
            err_cfg_q <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt_stage_q <= '0;
            stage_nf_q  <= nf_q[2:0];
            twdl_q      <= W_PTS'(nf_q[2:0]);
            last_q      <= (nfac_q == 3'd1);
            stage_go_q  <= 1'b1;
            wd          <= '0;
            state       <= S_RD;
          end
        end
        S_RD: begin
          // a write engine finishing early is remembered so WAIT_WR can move on at once
          if (bus.wr_end) wr_pend <= 1'b1;
          if (bus.rd_end) begin
            wd    <= '0;
            state <= S_WAIT_WR;
          end else if (wd_hit) begin
            err_to_q <= 1'b1;
            state    <= S_IDLE;
          end else begin
            wd <= wd_inc;
          end
        end
        S_WAIT_WR: begin
          if (bus.wr_end || wr_pend) begin
            wr_pend <= 1'b0;
            wd      <= '0;
            if (last_q) begin
              source_go_q <= 1'b1;
              state       <= S_SOURCE;
            end else begin
              cnt_stage_q <= next_idx;
              stage_nf_q  <= next_f;
              twdl_q      <= tw_mul;
              last_q      <= (next_idx == nfac_q - 3'd1);
              stage_go_q  <= 1'b1;
              state       <= S_RD;
            end
          end else if (wd_hit) begin
            err_to_q <= 1'b1;
            state    <= S_IDLE;
          end else begin
            wd <= wd_inc;
          end
        end
        S_SOURCE: begin
          if (bus.source_end) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else if (wd_hit) begin
            err_to_q <= 1'b1;
            state    <= S_IDLE;
          end else begin
            wd <= wd_inc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = (state != S_IDLE);
  assign bus.stage_go     = stage_go_q;
  assign bus.cnt_stage    = cnt_stage_q;
  assign bus.stage_nf     = stage_nf_q;
  assign bus.twdl_demontr = twdl_q;
  assign bus.last_stage   = last_q;
  assign bus.source_go    = source_go_q;
  assign bus.done         = done_q;
  assign bus.err_cfg      = err_cfg_q;
  assign bus.err_timeout  = err_to_q;
endmodule
